// File: rtl/n64_vbus_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : n64_vbus_tx_pkg
// Brief  : Shared video constants and types for the N64 VBUS transmitter.
// Rev    : 1.0
// ============================================================================
package n64_vbus_tx_pkg;

    localparam int color_width_i = 7;
    localparam int HCNT_W        = 11;
    localparam int VCNT_W        = 10;

    localparam logic [VCNT_W-1:0] V_TOTAL_NTSC = 10'd263;
    localparam logic [VCNT_W-1:0] V_TOTAL_PAL  = 10'd313;
    localparam logic [VCNT_W-1:0] V_ACT_NTSC   = 10'd240;
    localparam logic [VCNT_W-1:0] V_ACT_PAL    = 10'd288;

    localparam int CLAMP_LEN = 16;

    // Bit positions of the sync flags inside the phase-0 word
    localparam int SW_NCSYNC = 0;
    localparam int SW_NHSYNC = 1;
    localparam int SW_NCLAMP = 2;
    localparam int SW_NVSYNC = 3;

    localparam logic [1:0] PH_SYNC = 2'd0;
    localparam logic [1:0] PH_R    = 2'd1;
    localparam logic [1:0] PH_G    = 2'd2;
    localparam logic [1:0] PH_B    = 2'd3;

    localparam logic [1:0] PAT_BLACK = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_GRID  = 2'd2;
    localparam logic [1:0] PAT_RAMP  = 2'd3;

    // {R,G,B} per bar, bar 0 in the low bits: white..black
    localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

    typedef struct packed {
        logic       pal;
        logic       interlaced;
        logic [1:0] pattern;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{pal: 1'b0, interlaced: 1'b0, pattern: PAT_BLACK};

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [4:0] base;
        base = {2'b00, idx} + {1'b0, idx, 1'b0};
        return BAR_TABLE[base +: 3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/n64_vbus_tx_pattern.sv
`default_nettype none
// ============================================================================
// Module : n64_vbus_tx_pattern
// Brief  : Combinational test-pattern colour generator for the active window.
// Rev    : 1.0
// ============================================================================
module n64_vbus_tx_pattern
    import n64_vbus_tx_pkg::*;
#(
    parameter int H_ACT_LEN = 640
)(
    input  logic [HCNT_W-1:0]        hx,
    input  logic [4:0]               vx,
    input  logic [1:0]               pattern,
    input  logic                     active,
    output logic [color_width_i-1:0] R,
    output logic [color_width_i-1:0] G,
    output logic [color_width_i-1:0] B
);

    localparam int BAR_W = H_ACT_LEN / 8;

    logic [2:0] w_bar;
    logic [2:0] w_rgb;
    logic       w_grid;

    // Threshold chain instead of a divider: bar index = number of boundaries passed
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hx >= HCNT_W'(k * BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    assign w_rgb  = bar_rgb(w_bar);
    assign w_grid = (hx[4:0] == 5'd0) || (vx == 5'd0);

    always_comb begin
        R = '0;
        G = '0;
        B = '0;
        if (active) begin
            case (pattern)
                PAT_BLACK: ;
                PAT_BARS: begin
                    R = {color_width_i{w_rgb[2]}};
                    G = {color_width_i{w_rgb[1]}};
                    B = {color_width_i{w_rgb[0]}};
                end
                PAT_GRID: begin
                    R = {color_width_i{w_grid}};
                    G = {color_width_i{w_grid}};
                    B = {color_width_i{w_grid}};
                end
                PAT_RAMP: begin
                    R = hx[color_width_i-1:0];
                    G = hx[color_width_i-1:0];
                    B = hx[color_width_i-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/n64_vbus_tx.sv
`default_nettype none
// ============================================================================
// Module : n64_vbus_tx
// Brief  : N64-style VBUS video timing and test-pattern transmitter.
// Rev    : 1.0
// ============================================================================
module n64_vbus_tx
    import n64_vbus_tx_pkg::*;
#(
    parameter int H_TOTAL      = 773,
    parameter int H_SYNC       = 57,
    parameter int H_ACT_START  = 128,
    parameter int H_ACT_LEN    = 640,
    parameter int V_SYNC_LINES = 3,
    parameter int V_ACT_START  = 20
)(
    input  logic                     VCLK,
    input  logic                     VRST,
    input  logic                     enable,
    input  logic                     pal,
    input  logic                     interlaced,
    input  logic [1:0]               pattern,
    output logic                     nVDSYNC,
    output logic [color_width_i-1:0] VD_o,
    output logic                     frame_start,
    output logic                     field
);

    localparam logic [HCNT_W-1:0] c_H_LAST      = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] c_H_SYNC      = HCNT_W'(H_SYNC);
    localparam logic [HCNT_W-1:0] c_CLAMP_END   = HCNT_W'(H_SYNC + CLAMP_LEN);
    localparam logic [HCNT_W-1:0] c_H_ACT_START = HCNT_W'(H_ACT_START);
    localparam logic [HCNT_W-1:0] c_H_ACT_END   = HCNT_W'(H_ACT_START + H_ACT_LEN);
    localparam logic [VCNT_W-1:0] c_V_SYNC      = VCNT_W'(V_SYNC_LINES);
    localparam logic [VCNT_W-1:0] c_V_ACT_START = VCNT_W'(V_ACT_START);

    logic [1:0]               r_phase;
    logic [HCNT_W-1:0]        r_h;
    logic [VCNT_W-1:0]        r_v;
    logic                     r_field;
    cfg_t                     r_cfg;
    logic                     r_nvdsync;
    logic [color_width_i-1:0] r_vd;
    logic                     r_frame_start;
    logic                     r_field_o;

    logic                     w_origin;
    cfg_t                     w_cfg;
    logic [VCNT_W-1:0]        w_vtotal;
    logic [VCNT_W-1:0]        w_vact;
    logic                     w_h_last;
    logic                     w_v_last;
    logic                     w_nhsync;
    logic                     w_nvsync;
    logic                     w_ncsync;
    logic                     w_nclamp;
    logic                     w_active;
    logic [HCNT_W-1:0]        w_hx;
    logic [4:0]               w_vx;
    logic [color_width_i-1:0] w_r;
    logic [color_width_i-1:0] w_g;
    logic [color_width_i-1:0] w_b;
    logic [color_width_i-1:0] w_sync;
    logic [color_width_i-1:0] w_vd;

    // Config is live only on the field's first cycle; enable start lands there too
    assign w_origin = (r_phase == PH_SYNC) && (r_h == '0) && (r_v == '0);
    assign w_cfg    = w_origin ? '{pal: pal, interlaced: interlaced, pattern: pattern} : r_cfg;

    assign w_vtotal = (w_cfg.pal ? V_TOTAL_PAL : V_TOTAL_NTSC)
                    - {{(VCNT_W-1){1'b0}}, (w_cfg.interlaced & r_field)};
    assign w_vact   = w_cfg.pal ? V_ACT_PAL : V_ACT_NTSC;
    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == (w_vtotal - 10'd1));

    assign w_nhsync = (r_h >= c_H_SYNC);
    assign w_nvsync = (r_v >= c_V_SYNC);
    assign w_ncsync = w_nvsync ? w_nhsync : ~w_nhsync;
    assign w_nclamp = ~(w_nvsync && (r_h >= c_H_SYNC) && (r_h < c_CLAMP_END));

    assign w_active = (r_h >= c_H_ACT_START) && (r_h < c_H_ACT_END)
                   && (r_v >= c_V_ACT_START) && (r_v < (c_V_ACT_START + w_vact));
    assign w_hx     = r_h - c_H_ACT_START;
    assign w_vx     = 5'(r_v - c_V_ACT_START);

    n64_vbus_tx_pattern #(
        .H_ACT_LEN (H_ACT_LEN)
    ) u_pattern (
        .hx      (w_hx),
        .vx      (w_vx),
        .pattern (w_cfg.pattern),
        .active  (w_active),
        .R       (w_r),
        .G       (w_g),
        .B       (w_b)
    );

    always_comb begin
        w_sync            = '0;
        w_sync[SW_NVSYNC] = w_nvsync;
        w_sync[SW_NCLAMP] = w_nclamp;
        w_sync[SW_NHSYNC] = w_nhsync;
        w_sync[SW_NCSYNC] = w_ncsync;
    end

    always_comb begin
        w_vd = '0;
        case (r_phase)
            PH_SYNC: w_vd = w_sync;
            PH_R:    w_vd = w_r;
            PH_G:    w_vd = w_g;
            PH_B:    w_vd = w_b;
            default: w_vd = '0;
        endcase
    end

    always_ff @(posedge VCLK) begin
        if (VRST || !enable) begin
            r_phase       <= PH_SYNC;
            r_h           <= '0;
            r_v           <= '0;
            r_field       <= 1'b0;
            r_cfg         <= CFG_RESET;
            r_nvdsync     <= 1'b1;
            r_vd          <= '0;
            r_frame_start <= 1'b0;
            r_field_o     <= 1'b0;
        end else begin
            r_cfg         <= w_cfg;
            r_nvdsync     <= (r_phase != PH_SYNC);
            r_vd          <= w_vd;
            r_frame_start <= w_origin;
            r_field_o     <= r_field;
            r_phase       <= r_phase + 2'd1;
            if (r_phase == PH_B) begin
                if (w_h_last) begin
                    r_h <= '0;
                    if (w_v_last) begin
                        r_v     <= '0;
                        r_field <= w_cfg.interlaced ? ~r_field : 1'b0;
                    end else begin
                        r_v <= r_v + 10'd1;
                    end
                end else begin
                    r_h <= r_h + 11'd1;
                end
            end
        end
    end

    assign nVDSYNC     = r_nvdsync;
    assign VD_o        = r_vd;
    assign frame_start = r_frame_start;
    assign field       = r_field_o;

endmodule
`default_nettype wire

// File: tb/tb_n64_vbus_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_n64_vbus_tx
// Brief  : Scoreboard bench for n64_vbus_tx using a shortened line length.
// Rev    : 1.0
// ============================================================================
module tb_n64_vbus_tx;

    localparam int H_TOTAL      = 12;
    localparam int H_SYNC       = 2;
    localparam int H_ACT_START  = 4;
    localparam int H_ACT_LEN    = 8;
    localparam int V_SYNC_LINES = 3;
    localparam int V_ACT_START  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pal;
    logic       interlaced;
    logic [1:0] pattern;
    logic       nVDSYNC;
    logic [6:0] VD_o;
    logic       frame_start;
    logic       field;

    always #5 clk = ~clk;

    n64_vbus_tx #(
        .H_TOTAL      (H_TOTAL),
        .H_SYNC       (H_SYNC),
        .H_ACT_START  (H_ACT_START),
        .H_ACT_LEN    (H_ACT_LEN),
        .V_SYNC_LINES (V_SYNC_LINES),
        .V_ACT_START  (V_ACT_START)
    ) u_dut (
        .VCLK        (clk),
        .VRST        (rst),
        .enable      (enable),
        .pal         (pal),
        .interlaced  (interlaced),
        .pattern     (pattern),
        .nVDSYNC     (nVDSYNC),
        .VD_o        (VD_o),
        .frame_start (frame_start),
        .field       (field)
    );

    typedef struct {
        bit       rst;
        bit       nvd;
        bit [6:0] vd;
        bit       fs;
        bit       fld;
        int       h;
        int       v;
        int       ph;
        bit [1:0] pat;
        bit [1:0] pin;
        bit       mpal;
    } exp_t;

    exp_t sb_q[$];
    int   per_q[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    bit done    = 1'b0;
    int m_ph    = 0;
    int m_h     = 0;
    int m_v     = 0;
    int m_nfs   = 0;
    int dut_nfs = 0;
    int cyc     = 0;
    int last_fs = -1;
    bit m_fld   = 1'b0;
    bit m_pal   = 1'b0;
    bit m_il    = 1'b0;
    bit [1:0] m_pat = 2'd0;

    task automatic finish_bench();
        if (!done) begin
            done = 1'b1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
        if (n_bad >= 50) finish_bench();
    endtask

    // ch: 0 = R, 1 = G, 2 = B
    function automatic bit [6:0] f_col(int hx, int vx, bit [1:0] pat, int ch);
        bit [23:0] bars;
        bit [2:0]  rgb;
        int        b;
        bars = 24'b111_110_011_010_101_100_001_000;
        case (pat)
            2'd1: begin
                b   = hx / (H_ACT_LEN / 8);
                rgb = bars[23 - 3*b -: 3];
                return rgb[2 - ch] ? 7'h7F : 7'h00;
            end
            2'd2: return ((hx % 32) == 0 || (vx % 32) == 0) ? 7'h7F : 7'h00;
            2'd3: return 7'(hx % 128);
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: predicts the word the DUT registers at this edge
    always @(posedge clk) begin : p_model
        exp_t e;
        bit   nh, nv, nc, ncl, act;
        int   vt;
        e.pin = pattern;
        if (rst || !enable) begin
            m_ph = 0; m_h = 0; m_v = 0; m_fld = 1'b0;
            m_pal = 1'b0; m_il = 1'b0; m_pat = 2'd0;
            e.rst = 1'b1; e.nvd = 1'b1; e.vd = 7'h00; e.fs = 1'b0; e.fld = 1'b0;
            e.h = 0; e.v = 0; e.ph = 0; e.pat = 2'd0; e.mpal = 1'b0;
        end else begin
            if (m_ph == 0 && m_h == 0 && m_v == 0) begin
                m_pal = pal; m_il = interlaced; m_pat = pattern; m_nfs++;
            end
            e.rst = 1'b0; e.h = m_h; e.v = m_v; e.ph = m_ph; e.pat = m_pat; e.mpal = m_pal;
            e.fs  = (m_ph == 0 && m_h == 0 && m_v == 0);
            e.fld = m_fld;
            e.nvd = (m_ph != 0);
            nh  = (m_h >= H_SYNC);
            nv  = (m_v >= V_SYNC_LINES);
            nc  = nv ? nh : !nh;
            ncl = !(nv && m_h >= H_SYNC && m_h < H_SYNC + 16);
            act = (m_h >= H_ACT_START) && (m_h < H_ACT_START + H_ACT_LEN) &&
                  (m_v >= V_ACT_START) && (m_v < V_ACT_START + (m_pal ? 288 : 240));
            if (m_ph == 0)
                e.vd = {3'b000, nv, ncl, nh, nc};
            else
                e.vd = act ? f_col(m_h - H_ACT_START, m_v - V_ACT_START, m_pat, m_ph - 1) : 7'h00;
            m_ph++;
            if (m_ph == 4) begin
                m_ph = 0;
                m_h++;
                if (m_h == H_TOTAL) begin
                    m_h = 0;
                    m_v++;
                    vt = (m_pal ? 313 : 263) - ((m_il && m_fld) ? 1 : 0);
                    if (m_v == vt) begin
                        m_v = 0;
                        per_q.push_back(vt * H_TOTAL * 4);
                        m_fld = m_il ? !m_fld : 1'b0;
                    end
                end
            end
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : p_mon
        exp_t e;
        bit   act;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("nvdsync", int'(nVDSYNC), int'(e.nvd));
            chk("vd", int'(VD_o), int'(e.vd));
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("field", int'(field), int'(e.fld));
            if (e.rst) begin
                last_fs = -1;
            end else begin
                act = (e.h >= H_ACT_START) && (e.h < H_ACT_START + H_ACT_LEN) &&
                      (e.v >= V_ACT_START) && (e.v < V_ACT_START + (e.mpal ? 288 : 240));
                if (e.v == 0 && e.h == 1 && e.ph == 0)
                    chk("vsync_word", int'(VD_o), 'h05);
                if (e.pat == 2'd1 && e.v == V_ACT_START && e.h == H_ACT_START && e.ph != 0)
                    chk("bar_white", int'(VD_o), 'h7F);
                if (e.pat == 2'd1 && e.v == V_ACT_START && e.h == H_ACT_START + H_ACT_LEN/8 && e.ph != 0)
                    chk("bar_yellow", int'(VD_o), (e.ph == 3) ? 0 : 'h7F);
                if (e.pat == 2'd0 && e.pin == 2'd3 && act && e.ph != 0)
                    chk("hold_black", int'(VD_o), 0);
                if (e.pat == 2'd3 && e.v == V_ACT_START && act && e.ph != 0)
                    chk("ramp", int'(VD_o), (e.h - H_ACT_START) % 128);
                if (e.fs)
                    chk("field_at_fs", int'(field), int'(e.fld));
            end
            if (frame_start) begin
                dut_nfs++;
                if (last_fs >= 0) begin
                    if (per_q.size() == 0) chk("period_q", per_q.size(), 1);
                    else                   chk("frame_period", cyc - last_fs, per_q.pop_front());
                end
                last_fs = cyc;
            end
        end
    end

    initial begin
        int n_sync;
        rst = 1'b1; enable = 1'b0; pal = 1'b0; interlaced = 1'b0; pattern = 2'd0;
        n_sync = 0;
        repeat (5) begin
            @(negedge clk);
            if (!nVDSYNC) n_sync++;
        end
        enable = 1'b1; pattern = 2'd1;
        repeat (5) begin
            @(negedge clk);
            if (!nVDSYNC) n_sync++;
        end
        chk("rst_no_sync", n_sync, 0);
        chk("rst_vd", int'(VD_o), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_field", int'(field), 0);

        rst = 1'b0;
        @(negedge clk);
        chk("start_fs", int'(frame_start), 1);
        chk("start_nvd", int'(nVDSYNC), 0);

        repeat (6000) @(negedge clk);
        pattern = 2'd0;
        repeat (263 * H_TOTAL * 4) @(negedge clk);
        pattern = 2'd3; pal = 1'b1; interlaced = 1'b1;
        repeat (37000) @(negedge clk);

        for (int i = 0; i < 4 * H_TOTAL + 8 && !(m_ph == 2 && m_h == 5); i++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_nvd", int'(nVDSYNC), 1);
        chk("drop_vd", int'(VD_o), 0);
        chk("drop_fs", int'(frame_start), 0);
        repeat (3) @(negedge clk);

        pal = 1'b0; interlaced = 1'b0; pattern = 2'd2; enable = 1'b1;
        @(negedge clk);
        chk("reen_fs", int'(frame_start), 1);
        chk("reen_nvd", int'(nVDSYNC), 0);
        repeat (1500) @(negedge clk);

        chk("fs_count", dut_nfs, m_nfs);
        chk("period_left", per_q.size(), 0);
        finish_bench();
    end

endmodule
`default_nettype wire
